vga_timing_gen: RTL

Upstream stage of the VGA renderer. Divides the system clock into a pixel-rate enable and runs the horizontal and vertical scan counters. Produces pixelx/pixely, the sync pulses and the frame/line markers that the renderer and the DAC pins consume. Counter origin is the start of the sync pulse: sync, back porch, visible, front porch. With defaults, the visible area is pixelx 144..783 and pixely 35..514.

---
 rtl/vga_timing_gen.sv | 92 +++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA scan timing: divides the system clock to a pixel-rate enable and runs the
// horizontal/vertical counters, producing sync, visible-area and line/frame markers.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] pixelx,
  output logic [9:0] pixely,
  output logic       hsync,
  output logic       vsync,
  output logic       vga_clk,
  output logic       pix_en,
  output logic       active,
  output logic       line_end,
  output logic       frame_end,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
  localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W    = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W    = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_FIRST = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_LAST  = 10'(H_SYNC + H_BACK + H_VISIBLE - 1);
  localparam logic [9:0] V_ACT_FIRST = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT_LAST  = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    div_next = div + DIV_ONE;
    if (div == DIV_LAST) div_next = '0;
  end

  // Strobes and decodes come straight from the registered counters, so they
  // stay cycle-aligned with pixelx/pixely and reset to 0 along with them.
  assign pix_en    = (div == DIV_LAST);
  assign line_end  = pix_en && (pixelx == H_LAST);
  assign frame_end = line_end && (pixely == V_LAST);

  assign hsync  = (pixelx >= H_SYNC_W);
  assign vsync  = (pixely >= V_SYNC_W);
  assign active = (pixelx >= H_ACT_FIRST) && (pixelx <= H_ACT_LAST) &&
                  (pixely >= V_ACT_FIRST) && (pixely <= V_ACT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      div         <= '0;
      vga_clk     <= 1'b0;
      pixelx      <= '0;
      pixely      <= '0;
      frame_count <= '0;
    end else begin
      div     <= div_next;
      // Registered from the next divider phase so it equals (div >= CLK_DIV/2) every cycle.
      vga_clk <= (div_next >= DIV_HALF);

      if (pix_en) begin
        if (pixelx == H_LAST) pixelx <= '0;
        else                  pixelx <= pixelx + 10'd1;
      end

      if (line_end) begin
        if (pixely == V_LAST) pixely <= '0;
        else                  pixely <= pixely + 10'd1;
      end

      if (frame_end) frame_count <= frame_count + 8'd1;
    end
  end

endmodule
